// File: rtl/filter_sample_tx.sv
// rtl/filter_sample_tx.sv - I2S-style serial transmitter for signed filter samples (mono duplicated to L/R)
module filter_sample_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SCLK_HALF    = 2
) (
  input  logic                    sample_clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] POS_MAX  = BIT_W'(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-1:0] hold;
  logic                    hold_full;
  logic [SAMPLE_WIDTH-1:0] frame_reg;

  logic                    div_tc;
  logic                    shift_evt;
  logic                    frame_edge;
  logic [BIT_W-1:0]        bit_next;
  logic [BIT_W-1:0]        pos;
  logic [SAMPLE_WIDTH-1:0] shifted;
  logic                    serial_bit;

  assign in_ready = !hold_full;

  // Next slot position and the data bit that belongs to it (one-bit delay after each lrclk edge)
  always_comb begin
    div_tc     = (div_cnt == DIV_LAST);
    shift_evt  = enable && div_tc && sclk;
    bit_next   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
    pos        = (bit_next >= SLOT_C) ? bit_next - SLOT_C : bit_next;
    frame_edge = shift_evt && (bit_next == '0);
    shifted    = frame_reg << (pos - BIT_W'(1));
    serial_bit = 1'b0;
    if ((pos != '0) && (pos <= POS_MAX)) begin
      serial_bit = shifted[SAMPLE_WIDTH-1];
    end
  end

  // Link timing: bit clock divider, slot counter and registered serial outputs
  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      sclk        <= 1'b0;
      bit_cnt     <= LAST_BIT;
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else if (!enable) begin
      div_cnt     <= '0;
      sclk        <= 1'b0;
      bit_cnt     <= LAST_BIT;
      lrclk       <= 1'b1;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      underrun    <= frame_edge && !hold_full;
      if (div_tc) begin
        div_cnt <= '0;
        sclk    <= !sclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (shift_evt) begin
        bit_cnt <= bit_next;
        lrclk   <= (bit_next >= SLOT_C);
        sdata   <= serial_bit;
      end
    end
  end

  // One-entry holding buffer and per-frame sample latch
  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      frame_reg <= '0;
    end else begin
      if (frame_edge) begin
        frame_reg <= hold_full ? hold : '0;
      end
      if (in_valid && !hold_full) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end else if (frame_edge) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
